// File: rtl/twos_comp_seq.sv
// twos_comp_seq: word-level sequencer around the bit-serial two's-complement
// unit "invert". It accepts a WIDTH-bit operand, clears the serial unit for
// one cycle, streams the operand LSB-first through it, reassembles the serial
// result and holds it with zero/overflow flags until the consumer takes it.
//
// Ports
//   t_clk      system clock, rising edge
//   r          synchronous active-high reset (also clears the serial unit)
//   in_data    operand word          in_valid / in_ready   input handshake
//   ser_i      bit to invert.i       ser_r                 clear to invert.r
//   ser_y      bit from invert.y (combinational from ser_i)
//   out_data   -in_data mod 2^WIDTH  out_zero / out_ovf    status flags
//   out_valid / out_ready            output handshake
module twos_comp_seq #(
    parameter int WIDTH = 8
) (
    input  logic             t_clk,
    input  logic             r,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_i,
    output logic             ser_r,
    input  logic             ser_y,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero,
    output logic             out_ovf,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0]    LAST    = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MOSTNEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] in_q;
    logic [WIDTH-1:0] out_q;
    logic             zero_q;
    logic             ovf_q;

    always_ff @(posedge t_clk) begin
        if (r) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            in_q    <= '0;
            out_q   <= '0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        in_q    <= in_data;
                        cnt_q   <= '0;
                        // Flags come straight from the operand; the serial
                        // result is not needed to decide them.
                        zero_q  <= (in_data == '0);
                        ovf_q   <= (in_data == MOSTNEG);
                        state_q <= CLEAR;
                    end
                end
                CLEAR: state_q <= SHIFT;
                SHIFT: begin
                    // Right shift with the new bit entering at the MSB, so the
                    // first (LSB) result bit ends up at out_q[0].
                    out_q <= {ser_y, out_q[WIDTH-1:1]};
                    if (cnt_q == LAST) begin
                        cnt_q   <= '0;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // The serial unit is cleared by a system reset as well as by CLEAR, so an
    // aborted word cannot leave its "seen a 1" flag set.
    assign ser_r     = r | (state_q == CLEAR);
    assign ser_i     = (state_q == SHIFT) & in_q[cnt_q];
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_data  = out_q;
    assign out_zero  = zero_q;
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_twos_comp_seq.sv
// Bench for twos_comp_seq (WIDTH=8) with a behavioural model of the external
// serial unit. Results are checked through a queue of expected words.
module tb_twos_comp_seq;

    localparam int W = 8;

    logic         t_clk = 1'b0;
    logic         r = 1'b1;
    logic [W-1:0] in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         ser_i, ser_r, ser_y;
    logic [W-1:0] out_data;
    logic         out_zero, out_ovf, out_valid;
    logic         out_ready = 1'b1;

    twos_comp_seq #(.WIDTH(W)) dut (
        .t_clk(t_clk), .r(r), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .ser_i(ser_i), .ser_r(ser_r), .ser_y(ser_y),
        .out_data(out_data), .out_zero(out_zero), .out_ovf(out_ovf),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 t_clk = ~t_clk;

    // Serial unit: pass bits up to and including the first 1, invert after.
    logic seen;
    always_ff @(posedge t_clk) seen <= ser_r ? 1'b0 : (seen | ser_i);
    assign ser_y = ser_i ^ seen;

    typedef struct packed {
        logic [7:0] op;
        logic [7:0] res;
        logic       zero;
        logic       ovf;
    } vec_t;

    vec_t       tbl [6];
    logic [9:0] sbq [$];   // {ovf, zero, data}
    int         n_chk = 0;
    int         n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // One clock: scoreboard at the falling edge, then land #1 after the rise.
    task automatic step();
        logic [9:0] e;
        @(negedge t_clk);
        if (out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                chk("spurious_out", out_valid, 0);
            end else begin
                e = sbq.pop_front();
                chk("result", {out_ovf, out_zero, out_data}, e);
            end
        end
        @(posedge t_clk);
        #1;
    endtask

    task automatic idle_wait();
        int n = 0;
        while (!in_ready && n < 40) begin step(); n++; end
        chk("idle_wait", n < 40, 1);
    endtask

    task automatic send(input logic [7:0] op, input logic [9:0] exp, output int lat);
        in_data  = op;
        in_valid = 1'b1;
        idle_wait();
        sbq.push_back(exp);
        step();                         // acceptance edge
        in_valid = 1'b0;
        in_data  = 8'($urandom);        // must not affect the word in flight
        lat = 1;
        while (!out_valid && lat < 40) begin step(); lat++; end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int         lat, n;
        logic [7:0] si, sy;
        logic       bp_ok, any_v;

        tbl[0] = '{op: 8'h01, res: 8'hFF, zero: 1'b0, ovf: 1'b0};
        tbl[1] = '{op: 8'h00, res: 8'h00, zero: 1'b1, ovf: 1'b0};
        tbl[2] = '{op: 8'h80, res: 8'h80, zero: 1'b0, ovf: 1'b1};
        tbl[3] = '{op: 8'hFF, res: 8'h01, zero: 1'b0, ovf: 1'b0};
        tbl[4] = '{op: 8'h3C, res: 8'hC4, zero: 1'b0, ovf: 1'b0};
        tbl[5] = '{op: 8'h55, res: 8'hAB, zero: 1'b0, ovf: 1'b0};

        // Reset
        step(); step();
        chk("rst_ser_r", ser_r, 1);
        chk("rst_ser_i", ser_i, 0);
        r = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_flags", {out_zero, out_ovf}, 0);
        chk("rst_ser_r_low", ser_r, 0);

        // Table-driven words with latency
        for (int i = 0; i < 6; i++) begin
            send(tbl[i].op, {tbl[i].ovf, tbl[i].zero, tbl[i].res}, lat);
            chk("latency", lat, 10);
        end

        // Serial pin sequences for 0x06
        idle_wait();
        in_data  = 8'h06;
        in_valid = 1'b1;
        sbq.push_back({2'b00, 8'hFA});
        step();
        in_valid = 1'b0;
        chk("clear_ser_r", ser_r, 1);
        chk("clear_ser_i", ser_i, 0);
        for (int k = 0; k < 8; k++) begin
            step();
            si[k] = ser_i;
            sy[k] = ser_y;
        end
        chk("ser_i_seq", si, 8'h06);
        chk("ser_y_seq", sy, 8'hFA);
        step();
        chk("seq_valid_c10", out_valid, 1);

        // Back-to-back 0x7F then 0x81
        idle_wait();
        in_data  = 8'h7F;
        in_valid = 1'b1;
        sbq.push_back({2'b00, 8'h81});
        step();
        in_data = 8'h81;
        sbq.push_back({2'b00, 8'h7F});
        n = 0;
        while (!in_ready && n < 40) begin step(); n++; end
        chk("b2b_gap", n + 1, 11);
        step();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin step(); lat++; end
        chk("b2b_latency", lat, 10);

        // Backpressure on 0x05
        idle_wait();
        out_ready = 1'b0;
        send(8'h05, {2'b00, 8'hFB}, lat);
        chk("bp_latency", lat, 10);
        bp_ok = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (!(out_valid && out_data == 8'hFB && !in_ready)) bp_ok = 1'b0;
            in_valid = k[0];
            in_data  = 8'($urandom);
            step();
        end
        chk("bp_hold", bp_ok, 1);
        chk("bp_still_valid", out_valid, 1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        chk("bp_released", out_valid, 0);

        // Reset at SHIFT counter 3 of 0x3C
        idle_wait();
        in_data  = 8'h3C;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) step();
        r = 1'b1;
        #1;
        chk("abort_ser_r", ser_r, 1);
        step();
        r = 1'b0;
        #1;
        chk("abort_idle", in_ready, 1);
        chk("abort_no_valid", out_valid, 0);
        chk("abort_out_data", out_data, 0);
        any_v = 1'b0;
        for (int k = 0; k < 15; k++) begin
            step();
            any_v = any_v | out_valid;
        end
        chk("abort_no_output", any_v, 0);
        send(8'h02, {2'b00, 8'hFE}, lat);
        chk("post_abort_latency", lat, 10);

        step(); step();
        chk("sb_empty", sbq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
